// File: rtl/sequence_generator_pkg.sv
// Shared constants for the serial pattern transmitter: FSM state encoding and default widths.
package seq_gen_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int REP_W_DEF = 4;
    localparam int DIV_DEF   = 1;

    // Encoding is visible on the debug LEDs, so it is fixed rather than tool-chosen.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

endpackage

// File: rtl/sequence_generator_if.sv
// Request/serial-output bundle of the sequence generator; the requester is master, the generator slave.
interface sequence_generator_if
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF
);
    logic             i_start;
    logic [PAT_W-1:0] i_pattern;
    logic [LEN_W-1:0] i_len;
    logic [REP_W-1:0] i_repeat;
    logic             o_w_out;
    logic             o_w_valid;
    logic             o_busy;
    logic             o_done;
    logic             o_bad_cfg;
    logic [1:0]       o_state;

    modport master (
        output i_start, i_pattern, i_len, i_repeat,
        input  o_w_out, o_w_valid, o_busy, o_done, o_bad_cfg, o_state
    );

    modport slave (
        input  i_start, i_pattern, i_len, i_repeat,
        output o_w_out, o_w_valid, o_busy, o_done, o_bad_cfg, o_state
    );
endinterface

// File: rtl/sequence_generator_rate_divider.sv
// Bit-period divider: a down-counter that ticks every DIV cycles and restarts on load.
module rate_divider #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_load,
    output logic o_tick
);
    localparam int          CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    // NOTE: reset is synchronous and all state uses non-blocking assignments so every
    // register samples the same pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (!resetn)
            r_count <= '0;
        else if (i_load || r_count == '0)
            r_count <= RELOAD;
        else
            r_count <= r_count - CW'(1);
    end

    assign o_tick = (r_count == '0);
endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter feeding a sequence detector's w input, MSB-first with repeats.
// Define SEQGEN_GAP_EN to insert one idle bit period between repetitions.
module sequence_generator
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int DIV   = DIV_DEF
) (
    input logic                 clock,
    input logic                 resetn,
    sequence_generator_if.slave io
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);

    logic [1:0]       r_state;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic [REP_W-1:0] r_rep_left;
    logic             r_bad_cfg;

    logic             w_len_ok;
    logic             w_accept;
    logic             w_reject;
    logic             w_tick;
    logic [PAT_W-1:0] w_shifted;

    assign w_len_ok = (io.i_len != '0) && (io.i_len <= MAX_LEN);
    assign w_accept = (r_state == IDLE) && io.i_start && w_len_ok;
    assign w_reject = (r_state == IDLE) && io.i_start && !w_len_ok;

    rate_divider #(.DIV(DIV)) u_rate_divider (
        .clock  (clock),
        .resetn (resetn),
        .i_load (w_accept),
        .o_tick (w_tick)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_rep_left <= '0;
            r_bad_cfg  <= 1'b0;
        end else begin
            r_bad_cfg <= w_reject;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_pat      <= io.i_pattern;
                        r_len      <= io.i_len;
                        r_idx      <= io.i_len - LEN_W'(1);
                        r_rep_left <= io.i_repeat;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (r_idx != '0) begin
                            r_idx <= r_idx - LEN_W'(1);
                        end else if (r_rep_left == '0) begin
                            r_state <= DONE;
                        end else begin
                            // rep_left is only decremented after the zero check, so it cannot wrap.
                            r_rep_left <= r_rep_left - REP_W'(1);
`ifdef SEQGEN_GAP_EN
                            r_state <= GAP;
`else
                            r_idx   <= r_len - LEN_W'(1);
`endif
                        end
                    end
                end
                GAP: begin
`ifdef SEQGEN_GAP_EN
                    if (w_tick) begin
                        r_idx   <= r_len - LEN_W'(1);
                        r_state <= SHIFT;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure Moore decodes of the state, so reset clears them together with it.
    assign w_shifted    = r_pat >> r_idx;
    assign io.o_w_out   = (r_state == SHIFT) && w_shifted[0];
    assign io.o_w_valid = (r_state == SHIFT);
    assign io.o_busy    = (r_state == SHIFT) || (r_state == GAP);
    assign io.o_done    = (r_state == DONE);
    assign io.o_bad_cfg = r_bad_cfg;
    assign io.o_state   = r_state;
endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Serial pattern transmitter that drives the serial input of our sequence-detector FSMs.
- Captures a parallel pattern, length and repeat count on a start request.
- Shifts the pattern out MSB-first (bit len-1 down to bit 0), one bit per bit period, repeating the requested number of times.
- Sits between switch/key inputs and a detector's `w` input, so detector labs can be exercised automatically.

Parameters:
- PAT_W, 8: maximum pattern width in bits.
- LEN_W, 4: width of `len`. Must hold the value PAT_W.
- REP_W, 4: width of `repeat`.
- DIV, 1: clock cycles per bit period. DIV ≥ 1; DIV=1 means one bit per cycle.

Ports:
- clock, in, 1: system clock; all state updates on posedge.
- resetn, in, 1: synchronous active-low reset.
- start, in, 1: request; sampled only in IDLE.
- pattern, in, PAT_W: bits to send; bit len-1 is sent first.
- len, in, LEN_W: number of pattern bits, valid range 1..PAT_W.
- repeat, in, REP_W: additional repetitions; total sends = repeat+1.
- w_out, out, 1: serial data bit.
- w_valid, out, 1: w_out carries a pattern bit.
- busy, out, 1: transfer in progress.
- done, out, 1: one-cycle pulse after the final bit.
- bad_cfg, out, 1: one-cycle pulse when start is rejected.
- state, out, 2: current FSM state, for LEDR debug.

Behaviour:
- **Reset:** resetn is synchronous, active-low; clock is `clock`. On a posedge with resetn=0:
  - state=IDLE.
  - w_out, w_valid, busy, done, bad_cfg all 0.
  - Shadow registers, bit index, repeat counter and divider all 0.
  - Reset mid-transfer aborts immediately with no done pulse.
- **State encoding:** IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11.
- **IDLE:**
  - Outputs w_out=0, w_valid=0, busy=0.
  - start=1 with 1≤len≤PAT_W:
    - Latch pattern, len and repeat into shadow registers.
    - idx=len-1, rep_left=repeat, divider=DIV-1.
    - Next state SHIFT.
  - start=1 with len=0 or len>PAT_W: stay in IDLE, bad_cfg=1 on the next cycle.
- **SHIFT:**
  - Moore outputs: w_out=shadow[idx], w_valid=1, busy=1.
  - The divider decrements each cycle; a tick occurs when it reaches 0, then it reloads DIV-1.
  - On tick with idx>0: idx decrements.
  - On tick with idx=0 and rep_left=0: go to DONE.
  - On tick with idx=0 and rep_left>0: rep_left decrements, idx=len-1, stay in SHIFT (see optional feature for the gap variant).
- **DONE:** one cycle; done=1, busy=0, w_out=0, w_valid=0; next state IDLE.
- **Latency:** start sampled at edge k.
  - First bit visible from cycle k+1.
  - Each bit is held DIV cycles.
  - done is asserted in cycle k+1+DIV·len·(repeat+1) (no gaps).
  - A new start is accepted one cycle after done, once back in IDLE.
- **Simultaneous events and input changes:**
  - start while busy is ignored.
  - Changes to pattern, len or repeat during a transfer have no effect.
  - resetn=0 takes priority over every other input.
- **Width:** idx is LEN_W bits. rep_left is REP_W bits; it never underflows because it is checked for 0 before decrementing.

Optional Feature:
SEQGEN_GAP_EN
- **Defined:**
  - Between repetitions, the idx=0 tick with rep_left>0 enters GAP for one bit period (DIV cycles).
  - In GAP: w_out=0, w_valid=0, busy=1.
  - On the GAP tick, go back to SHIFT with idx=len-1; rep_left has already been decremented.
  - done timing gains repeat·DIV cycles.
- **Undefined:** the GAP state is unreachable; repetitions run back-to-back.

Decomposition:
- **Package `seq_gen_pkg`:**
  - State localparams IDLE/SHIFT/GAP/DONE.
  - Default widths.
- **Sub-module `rate_divider`:**
  - Parameter DIV.
  - Inputs clock, resetn, load.
  - Output tick.
  - Down-counter that reloads on load or after a tick; DIV=1 ticks every cycle.

Test Plan:
1. pattern=8'h0D, len=4, repeat=0, DIV=1, start pulse at cycle 0 → w_out=1,1,0,1 in cycles 1-4; w_valid=1 in cycles 1-4; done=1 only in cycle 5; state back to 00 in cycle 6.
2. pattern=8'h0F, len=4, repeat=2, DIV=1 → 12 consecutive 1s in cycles 1-12; done in cycle 13. With SEQGEN_GAP_EN: w_valid=0 in cycles 5 and 10; done in cycle 15.
3. len=0, start=1 → bad_cfg=1 for one cycle; busy stays 0. Repeat with len=9 and PAT_W=8 → same response.
4. DIV=3, pattern=8'b10, len=2 → w_out=1 in cycles 1-3, 0 in cycles 4-6; done in cycle 7.
5. resetn=0 in cycle 3 of a len=4 transfer → cycle 4 shows state=00, all outputs 0, no done pulse. start in cycle 5 → the transfer restarts cleanly.
6. start held high through the whole test 1 transfer, pattern changed in cycle 2 → output identical to test 1; a second transfer starts in cycle 6, with its first bit in cycle 7.
